// File: rtl/victim_writeback_buffer.sv
// victim_writeback_buffer
//   Collects evicted dirty cache lines word-by-word (any word order) into a
//   small circular FIFO of line entries, then drains each completed line to
//   memory as single-word writes on a req/ack handshake, lowest word first.
//   A snoop port reports whether a line address is still held in the buffer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   alloc_i/_adr_i    open a new line entry at the given line address
//   vic_valid_i       victim word strobe; vic_word_i selects the word,
//                     vic_dat_i carries the data
//   full_o, empty_o   no entry free / no entry allocated
//   fill_busy_o       an entry is open and still collecting words
//   snoop_adr_i       address to look up; snoop_hit_o is combinational
//   mem_req_o/_we_o   registered write request to memory
//   mem_adr_o/_dat_o  registered word address and write data
//   mem_ack_i         memory accepted the presented word
module victim_writeback_buffer #(
  parameter int unsigned WORD_WIDTH        = 32,
  parameter int unsigned ADR_WIDTH         = 32,
  parameter int unsigned WORD_OFFSET_WIDTH = 2,
  parameter int unsigned ENTRIES           = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_i,
  input  logic [ADR_WIDTH-1:0]         alloc_adr_i,
  input  logic                         vic_valid_i,
  input  logic [WORD_WIDTH-1:0]        vic_dat_i,
  input  logic [WORD_OFFSET_WIDTH-1:0] vic_word_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         fill_busy_o,
  input  logic [ADR_WIDTH-1:0]         snoop_adr_i,
  output logic                         snoop_hit_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADR_WIDTH-1:0]         mem_adr_o,
  output logic [WORD_WIDTH-1:0]        mem_dat_o,
  input  logic                         mem_ack_i
);

  localparam int unsigned WORDS    = 1 << WORD_OFFSET_WIDTH;
  localparam int unsigned LINE_LSB = WORD_OFFSET_WIDTH + 2;
  localparam int unsigned BASE_W   = ADR_WIDTH - LINE_LSB;
  localparam int unsigned PTR_W    = $clog2(ENTRIES);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic {
    D_IDLE,
    D_WRITE
  } drain_state_e;

  // Per-entry storage
  logic [BASE_W-1:0]     base_q [ENTRIES];
  logic [BASE_W-1:0]     base_d [ENTRIES];
  logic [WORD_WIDTH-1:0] word_q [ENTRIES][WORDS];
  logic [WORD_WIDTH-1:0] word_d [ENTRIES][WORDS];
  logic [WORDS-1:0]      mask_q [ENTRIES];
  logic [WORDS-1:0]      mask_d [ENTRIES];
  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [ENTRIES-1:0]    ready_q, ready_d;

  // FIFO bookkeeping
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  fill_busy_q, fill_busy_d;

  // Drain side
  drain_state_e                 state_q, state_d;
  logic [WORD_OFFSET_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                         mem_req_q, mem_req_d;
  logic                         mem_we_q, mem_we_d;
  logic [ADR_WIDTH-1:0]         mem_adr_q, mem_adr_d;
  logic [WORD_WIDTH-1:0]        mem_dat_q, mem_dat_d;

  logic full, empty, alloc_acc, free_entry, snoop_hit;

  // Line-offset bits of the address inputs are don't-care by design.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{alloc_adr_i[LINE_LSB-1:0], snoop_adr_i[LINE_LSB-1:0]};

  always_comb begin
    base_d      = base_q;
    word_d      = word_q;
    mask_d      = mask_q;
    valid_d     = valid_q;
    ready_d     = ready_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_busy_d = fill_busy_q;
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_req_d   = mem_req_q;
    mem_adr_d   = mem_adr_q;
    mem_dat_d   = mem_dat_q;
    free_entry  = 1'b0;

    // full is taken from the pre-edge count, so a same-cycle free never
    // lets an alloc through while full.
    full      = (count_q == CNT_W'(ENTRIES));
    empty     = (count_q == '0);
    alloc_acc = alloc_i && !full && !fill_busy_q;

    // Fill side: alloc and fill are mutually exclusive because alloc needs
    // fill_busy low, while a fill write needs it high.
    if (alloc_acc) begin
      base_d[wr_ptr_q]  = alloc_adr_i[ADR_WIDTH-1:LINE_LSB];
      mask_d[wr_ptr_q]  = '0;
      valid_d[wr_ptr_q] = 1'b1;
      ready_d[wr_ptr_q] = 1'b0;
      fill_busy_d       = 1'b1;
    end else if (fill_busy_q && vic_valid_i) begin
      word_d[wr_ptr_q][vic_word_i] = vic_dat_i;
      mask_d[wr_ptr_q][vic_word_i] = 1'b1;
      if (&mask_d[wr_ptr_q]) begin
        ready_d[wr_ptr_q] = 1'b1;
        fill_busy_d       = 1'b0;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
    end

    // Drain side
    case (state_q)
      D_IDLE: begin
        if (ready_q[rd_ptr_q]) begin
          state_d   = D_WRITE;
          wcnt_d    = '0;
          mem_req_d = 1'b1;
          mem_adr_d = {base_q[rd_ptr_q], {WORD_OFFSET_WIDTH{1'b0}}, 2'b00};
          mem_dat_d = word_q[rd_ptr_q][0];
        end
      end
      D_WRITE: begin
        if (mem_ack_i) begin
          if (wcnt_q != '1) begin
            wcnt_d    = wcnt_q + 1'b1;
            mem_adr_d = {base_q[rd_ptr_q], wcnt_d, 2'b00};
            mem_dat_d = word_q[rd_ptr_q][wcnt_d];
          end else begin
            free_entry        = 1'b1;
            valid_d[rd_ptr_q] = 1'b0;
            ready_d[rd_ptr_q] = 1'b0;
            mask_d[rd_ptr_q]  = '0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
            mem_req_d         = 1'b0;
            state_d           = D_IDLE;
          end
        end
      end
      default: state_d = D_IDLE;
    endcase

    mem_we_d = mem_req_d;
    count_d  = count_q + CNT_W'(alloc_acc) - CNT_W'(free_entry);
  end

  // Hit on any allocated entry; the entry freed on this edge is still valid
  // until the edge, so it keeps reporting a hit for this cycle.
  always_comb begin
    snoop_hit = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (base_q[i] == snoop_adr_i[ADR_WIDTH-1:LINE_LSB])) begin
        snoop_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
        for (int unsigned j = 0; j < WORDS; j++) begin
          word_q[i][j] <= '0;
        end
      end
      valid_q     <= '0;
      ready_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fill_busy_q <= 1'b0;
      state_q     <= D_IDLE;
      wcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_dat_q   <= '0;
    end else begin
      base_q      <= base_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fill_busy_q <= fill_busy_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_dat_q   <= mem_dat_d;
    end
  end

  assign full_o      = full;
  assign empty_o     = empty;
  assign fill_busy_o = fill_busy_q;
  assign snoop_hit_o = snoop_hit;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_adr_o   = mem_adr_q;
  assign mem_dat_o   = mem_dat_q;

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Testbench for victim_writeback_buffer: scoreboard of expected memory
// writes, filled when a line is written in and checked as writes are acked.
module tb_victim_writeback_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_i;
  logic [31:0] alloc_adr_i;
  logic        vic_valid_i;
  logic [31:0] vic_dat_i;
  logic [1:0]  vic_word_i;
  logic        full_o, empty_o, fill_busy_o;
  logic [31:0] snoop_adr_i;
  logic        snoop_hit_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_adr_o, mem_dat_o;
  logic        mem_ack_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] exp_q[$];

  victim_writeback_buffer #(
    .WORD_WIDTH(32),
    .ADR_WIDTH(32),
    .WORD_OFFSET_WIDTH(2),
    .ENTRIES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alloc_i(alloc_i),
    .alloc_adr_i(alloc_adr_i),
    .vic_valid_i(vic_valid_i),
    .vic_dat_i(vic_dat_i),
    .vic_word_i(vic_word_i),
    .full_o(full_o),
    .empty_o(empty_o),
    .fill_busy_o(fill_busy_o),
    .snoop_adr_i(snoop_adr_i),
    .snoop_hit_o(snoop_hit_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o),
    .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every accepted memory write must match the head.
  always @(negedge clk) begin
    if (!rst && mem_req_o && mem_ack_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'h0, mem_adr_o}, 64'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_adr", {32'h0, mem_adr_o}, {32'h0, e[63:32]});
        check("wr_dat", {32'h0, mem_dat_o}, {32'h0, e[31:0]});
        check("wr_we", {63'h0, mem_we_o}, 64'h1);
      end
    end
  end

  task automatic do_alloc(input logic [31:0] a);
    alloc_i     = 1'b1;
    alloc_adr_i = a;
    tick();
    alloc_i     = 1'b0;
  endtask

  // ord holds the word index written at step p in bits [2p+1:2p].
  task automatic fill_words(input logic [31:0] a, input logic [31:0] seed, input logic [7:0] ord);
    for (int p = 0; p < 4; p++) begin
      vic_valid_i = 1'b1;
      vic_word_i  = ord[2*p +: 2];
      vic_dat_i   = seed + 32'(ord[2*p +: 2]);
      tick();
    end
    vic_valid_i = 1'b0;
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back({(a & 32'hFFFF_FFF0) + 32'(w * 4), seed + 32'(w)});
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req_o && n < 50) begin
      tick();
      n++;
    end
    check(tag, {63'h0, mem_req_o}, 64'h1);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!(empty_o && !mem_req_o) && n < 200) begin
      tick();
      n++;
    end
    check(tag, {62'h0, empty_o, mem_req_o}, 64'h2);
  endtask

  initial begin
    rst         = 1'b1;
    alloc_i     = 1'b0;
    alloc_adr_i = '0;
    vic_valid_i = 1'b0;
    vic_dat_i   = '0;
    vic_word_i  = '0;
    snoop_adr_i = '0;
    mem_ack_i   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check("rst_req", {63'h0, mem_req_o}, 64'h0);
    check("rst_we", {63'h0, mem_we_o}, 64'h0);
    check("rst_adr", {32'h0, mem_adr_o}, 64'h0);
    check("rst_dat", {32'h0, mem_dat_o}, 64'h0);
    check("rst_flags", {60'h0, full_o, empty_o, fill_busy_o, snoop_hit_o}, 64'h4);

    // Stray strobe with no open entry
    vic_valid_i = 1'b1;
    tick();
    vic_valid_i = 1'b0;
    check("stray_fill", {62'h0, empty_o, fill_busy_o}, 64'h2);

    // Single line, out-of-order fill, ack tied high
    mem_ack_i = 1'b1;
    do_alloc(32'h0000_1230);
    check("t1_busy", {62'h0, fill_busy_o, empty_o}, 64'h2);
    fill_words(32'h0000_1230, 32'hA0, {2'd1, 2'd0, 2'd3, 2'd2});
    check("t1_lat1", {63'h0, mem_req_o}, 64'h0);
    tick();
    check("t1_lat2", {63'h0, mem_req_o}, 64'h1);
    check("t1_adr0", {32'h0, mem_adr_o}, 64'h1230);
    wait_empty("t1_empty");

    // Backpressure on word 1
    mem_ack_i = 1'b0;
    do_alloc(32'h0000_2230);
    fill_words(32'h0000_2230, 32'hB0, {2'd3, 2'd2, 2'd1, 2'd0});
    wait_req("t2_req");
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_adr", {32'h0, mem_adr_o}, 64'h2234);
      check("t2_hold_dat", {32'h0, mem_dat_o}, 64'hB1);
      tick();
    end
    mem_ack_i = 1'b1;
    tick();
    check("t2_next_adr", {32'h0, mem_adr_o}, 64'h2238);
    wait_empty("t2_empty");

    // Full with two entries, then wrap-around
    mem_ack_i = 1'b0;
    do_alloc(32'h0000_3000);
    fill_words(32'h0000_3000, 32'hC0, {2'd3, 2'd2, 2'd1, 2'd0});
    do_alloc(32'h0000_4000);
    fill_words(32'h0000_4000, 32'hD0, {2'd0, 2'd1, 2'd2, 2'd3});
    check("t3_full", {63'h0, full_o}, 64'h1);
    do_alloc(32'h0000_5000);
    check("t3_alloc_ignored", {62'h0, fill_busy_o, full_o}, 64'h1);
    snoop_adr_i = 32'h0000_5000;
    #1 check("t3_snoop_rejected", {63'h0, snoop_hit_o}, 64'h0);
    mem_ack_i = 1'b1;
    begin
      int n = 0;
      while (full_o && n < 50) begin
        tick();
        n++;
      end
    end
    check("t3_not_full", {63'h0, full_o}, 64'h0);
    do_alloc(32'h0000_6000);
    check("t3_wrap_alloc", {63'h0, fill_busy_o}, 64'h1);
    fill_words(32'h0000_6000, 32'hE0, {2'd2, 2'd0, 2'd3, 2'd1});
    wait_empty("t3_empty");

    // Snoop
    mem_ack_i = 1'b0;
    do_alloc(32'h8000_0040);
    fill_words(32'h8000_0040, 32'hF0, {2'd3, 2'd2, 2'd1, 2'd0});
    snoop_adr_i = 32'h8000_004C;
    #1 check("t4_snoop_hit", {63'h0, snoop_hit_o}, 64'h1);
    snoop_adr_i = 32'h8000_0050;
    #1 check("t4_snoop_miss", {63'h0, snoop_hit_o}, 64'h0);
    snoop_adr_i = 32'h8000_0040;
    wait_req("t4_req");
    mem_ack_i = 1'b1;
    begin
      int n = 0;
      while (!(mem_req_o && mem_adr_o[3:2] == 2'd3) && n < 20) begin
        tick();
        n++;
      end
    end
    check("t4_last_word", {62'h0, mem_adr_o[3:2]}, 64'h3);
    check("t4_snoop_final_ack", {63'h0, snoop_hit_o}, 64'h1);
    tick();
    check("t4_snoop_freed", {63'h0, snoop_hit_o}, 64'h0);
    wait_empty("t4_empty");

    // Alloc on the same cycle as the final ack of the only line
    mem_ack_i = 1'b0;
    do_alloc(32'h0000_7000);
    fill_words(32'h0000_7000, 32'h70, {2'd3, 2'd2, 2'd1, 2'd0});
    wait_req("t5_req");
    mem_ack_i = 1'b1;
    begin
      int n = 0;
      while (!(mem_req_o && mem_adr_o[3:2] == 2'd3) && n < 20) begin
        tick();
        n++;
      end
    end
    check("t5_last_word", {62'h0, mem_adr_o[3:2]}, 64'h3);
    alloc_i     = 1'b1;
    alloc_adr_i = 32'h0000_7100;
    tick();
    alloc_i = 1'b0;
    check("t5_sim_alloc", {61'h0, fill_busy_o, empty_o, full_o}, 64'h4);
    fill_words(32'h0000_7100, 32'h71, {2'd3, 2'd2, 2'd1, 2'd0});
    do_alloc(32'h0000_7200);
    check("t5_count_two", {62'h0, fill_busy_o, full_o}, 64'h3);
    fill_words(32'h0000_7200, 32'h72, {2'd0, 2'd1, 2'd2, 2'd3});
    wait_empty("t5_empty");

    // Reset mid-drain
    mem_ack_i = 1'b0;
    do_alloc(32'h0000_9000);
    fill_words(32'h0000_9000, 32'h90, {2'd3, 2'd2, 2'd1, 2'd0});
    wait_req("t6_req");
    mem_ack_i = 1'b1;
    begin
      int n = 0;
      while (!(mem_req_o && mem_adr_o[3:2] == 2'd2) && n < 20) begin
        tick();
        n++;
      end
    end
    check("t6_word2", {62'h0, mem_adr_o[3:2]}, 64'h2);
    mem_ack_i = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t6_req_dropped", {63'h0, mem_req_o}, 64'h0);
    check("t6_empty", {62'h0, empty_o, fill_busy_o}, 64'h2);
    mem_ack_i = 1'b1;
    repeat (10) tick();
    check("t6_no_writes", {63'h0, mem_req_o}, 64'h0);

    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/victim_writeback_buffer.md
# victim_writeback_buffer

Write-back buffer that sits directly downstream of the 4-way data cache's MSHR victim port. The cache streams the words of an evicted dirty line into it, one word per strobe, in any word order. Once a line is complete, the buffer drains it to main memory as four single-word write transactions on a req/ack handshake. A snoop port lets the cache stall a refill whose line is still pending write-back, so stale memory is never read.

## Interface
- WORD_WIDTH, 32, data word width
- ADR_WIDTH, 32, byte address width
- WORD_OFFSET_WIDTH, 2, word-in-line index width (line = 4 words, 16 bytes)
- ENTRIES, 2, number of line entries (power of two, ≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- alloc_i  in  1  open a new line entry
- alloc_adr_i  in  ADR_WIDTH  victim line address; bits [3:0] ignored
- vic_valid_i  in  1  victim word strobe
- vic_dat_i  in  WORD_WIDTH  victim word data
- vic_word_i  in  WORD_OFFSET_WIDTH  victim word index
- full_o  out  1  no entry free; combinational from count
- empty_o  out  1  no entry allocated
- fill_busy_o  out  1  an entry is open and still filling
- snoop_adr_i  in  ADR_WIDTH  address to check
- snoop_hit_o  out  1  combinational; line pending in buffer
- mem_req_o  out  1  registered write request
- mem_we_o  out  1  registered; always 1 while mem_req_o=1
- mem_adr_o  out  ADR_WIDTH  registered word address
- mem_dat_o  out  WORD_WIDTH  registered write data
- mem_ack_i  in  1  memory accepted current word

## Operation
- Storage: circular FIFO of ENTRIES. Each entry holds base[ADR_WIDTH-1:4], 4 words, a 4-bit word-valid mask and a ready flag. Pointers wr_ptr/rd_ptr wrap modulo ENTRIES. count = allocated entries (filling + ready).
- Alloc is accepted only when alloc_i=1, full_o=0 and fill_busy_o=0. On accept:
  - the entry at wr_ptr takes the base address and clears its mask;
  - fill_busy_o=1 and count+1.
  - Alloc attempts that are not accepted are ignored. There is no error flag.
- Fill: vic_valid_i=1 while fill_busy_o=1 writes vic_dat_i into word vic_word_i of the open entry and sets that mask bit.
  - A repeat write to an already-valid word overwrites the data; the mask is unchanged.
  - vic_valid_i with no open entry is ignored.
- When the mask reaches 4'b1111, the entry becomes ready on the same edge as the last word write, fill_busy_o drops, and wr_ptr advances.
- Alloc and the final fill word may occur in the same cycle. Alloc is ignored because fill_busy_o is still 1.
- Drain FSM has two states:
  - D_IDLE: if the head entry (rd_ptr) is ready, go to D_WRITE with wcnt=0.
  - D_WRITE: mem_req_o=1, mem_adr_o={base,wcnt,2'b00}, mem_dat_o=word[wcnt]. Outputs hold stable until mem_ack_i=1.
  - On an ack with wcnt<3: wcnt+1, and the next word is presented the following cycle with req still high.
  - On an ack with wcnt=3: free the entry, rd_ptr+1, count-1, go to D_IDLE, drop mem_req_o.
- Words drain in ascending order 0..3 regardless of fill order.
- snoop_hit_o=1 when any allocated entry's base equals snoop_adr_i[ADR_WIDTH-1:4]. This covers filling, ready and currently-draining entries. The entry being freed on this edge still reports a hit in this cycle.
- Simultaneous alloc and drain-free: count net unchanged. full_o is evaluated from the pre-edge count, so an alloc while full is ignored even when an entry frees that same cycle.

## Timing
- Reset values:
  - mem_req_o=0, mem_we_o=0, mem_adr_o=0, mem_dat_o=0;
  - full_o=0, empty_o=1, fill_busy_o=0, snoop_hit_o=0;
  - pointers, count and wcnt = 0; all masks and ready flags cleared.
- Reset mid-drain or mid-fill discards all contents. mem_req_o is 0 on the cycle after rst is sampled.
- Fill-complete edge to first mem_req_o=1: 2 cycles (ready flag, then D_IDLE→D_WRITE registers outputs).
- With ack in the same cycle as each request, a line drains in 4 req cycles. There is one idle cycle (mem_req_o=0) between back-to-back lines.
- mem_ack_i is sampled only while mem_req_o=1. Acks while mem_req_o=0 are ignored.

## Test plan
- Single line, out-of-order fill:
  - Stimulus: alloc 0x0000_1230, then words 2,3,0,1 = 0xA2,0xA3,0xA0,0xA1; mem_ack_i tied high.
  - Response: writes to 0x1230/4/8/C with data 0xA0..0xA3 in order, first req 2 cycles after word 1, empty_o=1 afterwards.
- Backpressure:
  - Stimulus: ack withheld for 5 cycles on word 1.
  - Response: mem_adr_o=0x...34 and mem_dat_o held stable for those 5 cycles, then word 2 presented the next cycle.
- Full, with ENTRIES=2:
  - Stimulus: fill two lines with ack held low, then attempt a third alloc.
  - Response: full_o=1, third alloc ignored. After line 0 drains, full_o=0 and the next alloc is accepted into slot 0 (wrap-around).
- Snoop:
  - Stimulus: line 0x8000_0040 pending, snoop 0x8000_004C, then 0x8000_0050.
  - Response: snoop_hit_o 1, then 0. Snooping 0x8000_0040 on the final-ack cycle gives 1, and 0 on the next cycle.
- Simultaneous events:
  - Stimulus: while count=1 and the last word is acked, alloc a new line in the same cycle.
  - Response: alloc accepted, count stays 1.
- Reset mid-drain:
  - Stimulus: rst pulsed during word 2 of a drain.
  - Response: mem_req_o=0 the next cycle, empty_o=1, no further memory writes.
